serial_sum_stream: RTL and testbench

Parametrised successor of the serial accumulator. After a start command it accumulates a programmable number of samples, N, from a valid/ready input stream. Width, signedness and wrap-vs-saturate mode are selectable, and overflow is reported. The result is held with a done flag until the consumer acknowledges it. It sits between a sample source and a control FSM as a reusable reduction engine.

---
 rtl/serial_sum_stream.sv | 117 +++++++++++
 tb/tb_serial_sum_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_stream.sv
// Start-triggered reduction engine: sums N samples from a valid/ready stream,
// with selectable signedness, wrap/saturate mode and sticky overflow reporting.
module serial_sum_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_i,
  input  logic              sat_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic              ack_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  localparam int EXT_W = ACC_W + 1 - DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, count_q;
  logic               sat_q, ovf_q;
  logic [ACC_W-1:0]   sum_q;

  logic               beat, ovf_now;
  logic [ACC_W:0]     sum_ext, data_ext, sum_full;
  logic [ACC_W-1:0]   sat_val, sum_next;

  // One extra bit of headroom: carry-out (unsigned) or a top-two-bit
  // disagreement (signed) flags a result outside the ACC_W range.
  always_comb begin
    if (SIGNED != 0) begin
      data_ext = {{EXT_W{data_i[DATA_W-1]}}, data_i};
      sum_ext  = {sum_q[ACC_W-1], sum_q};
    end else begin
      data_ext = {{EXT_W{1'b0}}, data_i};
      sum_ext  = {1'b0, sum_q};
    end
    sum_full = sum_ext + data_ext;
    if (SIGNED != 0) begin
      ovf_now = sum_full[ACC_W] ^ sum_full[ACC_W-1];
      sat_val = sum_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_now = sum_full[ACC_W];
      sat_val = '1;
    end
    sum_next = (ovf_now && sat_q) ? sat_val : sum_full[ACC_W-1:0];
  end

  assign beat = data_valid_i && data_ready_o;

  always_comb begin
    state_d      = state_q;
    data_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = (n_i == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        data_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (data_valid_i && (count_q == n_q - CNT_W'(1))) state_d = DONE;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      n_q     <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        n_q     <= n_i;
        sat_q   <= sat_i;
        sum_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (beat) begin
        sum_q   <= sum_next;
        count_q <= count_q + CNT_W'(1);
        if (ovf_now) ovf_q <= 1'b1;
      end
    end
  end

  assign sum_o   = sum_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_sum_stream.sv
// Drives one shared stimulus into three parameterisations (16b unsigned,
// 8b unsigned, 8b signed) and checks each against an arithmetic model.
module tb_serial_sum_stream;

  logic       clk = 1'b0;
  logic       rst_n, start, sat_in, valid, ack;
  logic [7:0] n_in, data;

  logic        rdy0, bsy0, dn0, ovf0;
  logic        rdy1, bsy1, dn1, ovf1;
  logic        rdy2, bsy2, dn2, ovf2;
  logic [15:0] sum0;
  logic [7:0]  sum1, sum2, cnt0, cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_sum_stream #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_in), .sat_i(sat_in),
    .data_i(data), .data_valid_i(valid), .data_ready_o(rdy0), .busy_o(bsy0),
    .done_o(dn0), .ack_i(ack), .sum_o(sum0), .count_o(cnt0), .ovf_o(ovf0));

  serial_sum_stream #(.DATA_W(8), .ACC_W(8), .CNT_W(8), .SIGNED(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_in), .sat_i(sat_in),
    .data_i(data), .data_valid_i(valid), .data_ready_o(rdy1), .busy_o(bsy1),
    .done_o(dn1), .ack_i(ack), .sum_o(sum1), .count_o(cnt1), .ovf_o(ovf1));

  serial_sum_stream #(.DATA_W(8), .ACC_W(8), .CNT_W(8), .SIGNED(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_i(n_in), .sat_i(sat_in),
    .data_i(data), .data_valid_i(valid), .data_ready_o(rdy2), .busy_o(bsy2),
    .done_o(dn2), .ack_i(ack), .sum_o(sum2), .count_o(cnt2), .ovf_o(ovf2));

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 result held. Sums are kept as true
  // integers in the instance's numeric range.
  int     P_ACC[3] = '{16, 8, 8};
  bit     P_SGN[3] = '{0, 0, 1};
  int     m_phase = 0;
  int     m_n = 0, m_cnt = 0;
  bit     m_sat = 0, m_live = 0;
  longint m_sum[3];
  bit     m_ovf[3];

  task automatic model_add(input int i, input int d);
    longint x, t, hi, lo, m;
    m  = longint'(1) << P_ACC[i];
    x  = (P_SGN[i] && d >= 128) ? longint'(d - 256) : longint'(d);
    hi = P_SGN[i] ? (m / 2) - 1 : m - 1;
    lo = P_SGN[i] ? -(m / 2) : 0;
    t  = m_sum[i] + x;
    if (t > hi || t < lo) begin
      m_ovf[i] = 1'b1;
      if (m_sat) t = (t > hi) ? hi : lo;
      else begin
        t = ((t % m) + m) % m;
        if (t > hi) t = t - m;
      end
    end
    m_sum[i] = t;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1'b1; m_phase = 0; m_cnt = 0; m_n = 0; m_sat = 0;
      for (int i = 0; i < 3; i++) begin m_sum[i] = 0; m_ovf[i] = 0; end
    end else begin
      case (m_phase)
        0: if (start) begin
          m_n = int'(n_in); m_sat = sat_in; m_cnt = 0;
          for (int i = 0; i < 3; i++) begin m_sum[i] = 0; m_ovf[i] = 0; end
          m_phase = (n_in == 0) ? 2 : 1;
        end
        1: if (valid) begin
          for (int i = 0; i < 3; i++) model_add(i, int'(data));
          m_cnt++;
          if (m_cnt == m_n) m_phase = 2;
        end
        default: if (ack) m_phase = 0;
      endcase
    end
  end

  task automatic cmp_inst(input int i, input longint sum, input int cnt, input bit ovf,
                          input bit rdy, input bit bsy, input bit dn);
    longint mask;
    mask = (longint'(1) << P_ACC[i]) - 1;
    check($sformatf("u%0d.sum", i),   sum, m_sum[i] & mask);
    check($sformatf("u%0d.count", i), cnt, m_cnt);
    check($sformatf("u%0d.ovf", i),   ovf, m_ovf[i]);
    check($sformatf("u%0d.ready", i), rdy, m_phase == 1);
    check($sformatf("u%0d.busy", i),  bsy, m_phase != 0);
    check($sformatf("u%0d.done", i),  dn,  m_phase == 2);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      cmp_inst(0, longint'(sum0), int'(cnt0), ovf0, rdy0, bsy0, dn0);
      cmp_inst(1, longint'(sum1), int'(cnt1), ovf1, rdy1, bsy1, dn1);
      cmp_inst(2, longint'(sum2), int'(cnt2), ovf2, rdy2, bsy2, dn2);
    end
  end

  task automatic do_start(input int n, input bit sat);
    start = 1'b1; n_in = 8'(n); sat_in = sat;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Each sample k is preceded by g[k] idle cycles carrying junk data.
  task automatic feed(input int cnt, input int s[8], input int g[8]);
    for (int k = 0; k < cnt; k++) begin
      for (int j = 0; j < g[k]; j++) begin
        valid = 1'b0; data = 8'hAA; @(negedge clk);
      end
      valid = 1'b1; data = 8'(s[k]); @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 20;
    while (!dn0 && budget > 0) begin @(negedge clk); budget--; end
    check("done_timeout", longint'(dn0), 1);
  endtask

  task automatic ack_after(input int hold);
    repeat (hold) @(negedge clk);
    ack = 1'b1; @(negedge clk);
    ack = 1'b0;
    check("done_fall", longint'(dn0), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; n_in = 0; sat_in = 0; data = 0; valid = 0; ack = 0;
    repeat (2) @(negedge clk);
    check("rst_sum", longint'(sum0), 0);
    check("rst_busy", longint'(bsy0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, continuous valid
    do_start(4, 0);
    feed(4, '{10, 20, 30, 40, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    check("done_latency", longint'(dn0), 1);
    check("basic_sum", longint'(sum0), 100);
    check("basic_cnt", longint'(cnt0), 4);
    check("basic_ovf", longint'(ovf0), 0);
    ack_after(5);
    check("idle_hold_sum", longint'(sum0), 100);

    // Gapped stream: valid 1,0,0,1,0,1
    do_start(3, 0);
    feed(3, '{5, 7, 9, 0, 0, 0, 0, 0}, '{0, 2, 1, 0, 0, 0, 0, 0});
    wait_done();
    check("gap_sum", longint'(sum0), 21);
    ack_after(1);

    // Unsigned overflow, wrap then saturate
    do_start(3, 0);
    feed(3, '{200, 100, 50, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    wait_done();
    check("wrap_sum8", longint'(sum1), 94);
    check("wrap_ovf8", longint'(ovf1), 1);
    check("wide_sum16", longint'(sum0), 350);
    ack_after(1);
    do_start(3, 1);
    feed(3, '{200, 100, 50, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    wait_done();
    check("sat_sum8", longint'(sum1), 255);
    check("sat_ovf8", longint'(ovf1), 1);
    ack_after(1);

    // Signed saturation: 100 + 100 clamps to 127, then -50
    do_start(3, 1);
    feed(3, '{100, 100, 206, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    wait_done();
    check("ssat_sum", longint'(sum2), 77);
    check("ssat_ovf", longint'(ovf2), 1);
    ack_after(2);

    // n = 0 with valid held high: no beats
    valid = 1'b1; data = 8'd33;
    do_start(0, 0);
    check("n0_done", longint'(dn0), 1);
    check("n0_cnt", longint'(cnt0), 0);
    check("n0_sum", longint'(sum0), 0);
    valid = 1'b0;
    ack_after(1);

    // start during ACCUM and during DONE (with ack) is ignored
    do_start(2, 0);
    start = 1'b1; n_in = 8'd7; @(negedge clk); start = 1'b0;
    feed(2, '{3, 4, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});
    wait_done();
    check("ign_sum", longint'(sum0), 7);
    check("ign_cnt", longint'(cnt0), 2);
    start = 1'b1; ack = 1'b1; @(negedge clk);
    start = 1'b0; ack = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", longint'(bsy0), 0);
    check("ign_idle_sum", longint'(sum0), 7);

    // Reset after 2 of 5 beats, then a fresh run
    do_start(5, 0);
    feed(2, '{11, 12, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    check("abort_sum", longint'(sum0), 0);
    check("abort_cnt", longint'(cnt0), 0);
    check("abort_busy", longint'(bsy0), 0);
    @(negedge clk);
    do_start(2, 0);
    feed(2, '{1, 2, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    wait_done();
    check("rerun_sum", longint'(sum0), 3);
    ack_after(1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
